// File: rtl/ma_lsu_initiator_if.sv
// Word-addressed data-memory bus between the MA-stage initiator and the memory responder.
interface ma_lsu_initiator_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/ma_lsu_initiator.sv
// MA-stage load/store initiator: turns isLd/isSt into a req/ack memory transaction and stalls until done.
// Optional request timeout with ma_err pulse is enabled by defining LSU_TIMEOUT_EN.
module ma_lsu_initiator #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ma_valid,
    input  logic                 isLd,
    input  logic                 isSt,
    input  logic [31:0]          aluResult,
    input  logic [31:0]          op2,
    output logic [31:0]          ldResult,
    output logic                 stall,
    output logic                 ma_err,
    ma_lsu_initiator_if.master   mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        start;
    logic        ack_seen;
    logic        expire;
    logic        is_load;
    logic [31:0] ld_data;

    // Bits outside the word address carry no meaning for a word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aluResult[31:ADDR_W+2], aluResult[1:0]};

    // Gating with rst_n keeps stall low while reset is held, even if MA still shows a memory op.
    assign start    = rst_n & ma_valid & (isLd | isSt);
    assign ack_seen = (state == REQ) & mem.mem_ack;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (ack_seen || expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall    = ((state == IDLE) && start) || (state == REQ);
        ldResult = ((state == DONE) && is_load) ? ld_data : 32'h0;
    end

    // NOTE: only a handful of control/data flops here, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= 32'h0;
            is_load       <= 1'b0;
            ld_data       <= 32'h0;
        end else if ((state == IDLE) && start) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= isSt & ~isLd;
            mem.mem_addr  <= aluResult[ADDR_W+1:2];
            mem.mem_wdata <= op2;
            is_load       <= isLd;
        end else if ((state == REQ) && (ack_seen || expire)) begin
            mem.mem_req <= 1'b0;
            ld_data     <= (ack_seen && is_load) ? mem.mem_rdata : 32'h0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // Counter holds the number of ack-less REQ cycles already elapsed; the last one expires.
    assign expire = (state == REQ) && !mem.mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            ma_err   <= 1'b0;
        end else begin
            ma_err <= expire;
            if ((state == IDLE) && start)
                wait_cnt <= '0;
            else if ((state == REQ) && !mem.mem_ack)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign expire         = 1'b0;
    assign ma_err         = 1'b0;
`endif

endmodule

// File: tb/tb_ma_lsu_initiator.sv
// Directed bench for ma_lsu_initiator: per-cycle vector table plus reset-abort and timeout sequences.
module tb_ma_lsu_initiator;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ma_valid, isLd, isSt;
    logic [31:0] aluResult, op2;
    logic [31:0] ldResult;
    logic        stall, ma_err;

    int n_checks = 0;
    int n_errors = 0;

    ma_lsu_initiator_if #(.ADDR_W(ADDR_W)) mem ();

    ma_lsu_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ma_valid  (ma_valid),
        .isLd      (isLd),
        .isSt      (isSt),
        .aluResult (aluResult),
        .op2       (op2),
        .ldResult  (ldResult),
        .stall     (stall),
        .ma_err    (ma_err),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv, ld, st;
        logic [31:0] alu, op2, rd;
        logic        ack;
        logic        e_stall, e_req, e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata, e_ld;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic ld, input logic st, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [31:0] rd, input logic ack);
        ma_valid      = mv;
        isLd          = ld;
        isSt          = st;
        aluResult     = alu;
        op2           = d2;
        mem.mem_rdata = rd;
        mem.mem_ack   = ack;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from posedge.
    task automatic cycle(input logic mv, input logic ld, input logic st, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [31:0] rd, input logic ack);
        @(negedge clk);
        drive(mv, ld, st, alu, d2, rd, ack);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic e_stall, input logic e_req,
                             input logic [31:0] e_ld, input logic e_err);
        check({tag, ".stall"},    32'(stall),       32'(e_stall));
        check({tag, ".mem_req"},  32'(mem.mem_req), 32'(e_req));
        check({tag, ".ldResult"}, ldResult,         e_ld);
        check({tag, ".ma_err"},   32'(ma_err),      32'(e_err));
    endtask

    initial begin
        // Store to 0x10, ack on the third REQ cycle.
        vecs[0]  = '{1,0,1, 32'h10, 32'hCAFEF00D, 32'h0, 0,  1,0,0, 10'd0, 32'h0,        32'h0};
        vecs[1]  = '{1,0,1, 32'h10, 32'hCAFEF00D, 32'h0, 0,  1,1,1, 10'd4, 32'hCAFEF00D, 32'h0};
        vecs[2]  = '{1,0,1, 32'h10, 32'hCAFEF00D, 32'h0, 0,  1,1,1, 10'd4, 32'hCAFEF00D, 32'h0};
        vecs[3]  = '{1,0,1, 32'h10, 32'hCAFEF00D, 32'h0, 1,  1,1,1, 10'd4, 32'hCAFEF00D, 32'h0};
        vecs[4]  = '{1,0,1, 32'h10, 32'hCAFEF00D, 32'h0, 0,  0,0,1, 10'd4, 32'hCAFEF00D, 32'h0};
        // Load from 0x13 (word 4), ack in the first REQ cycle.
        vecs[5]  = '{1,1,0, 32'h13, 32'h0, 32'h0,        0,  1,0,1, 10'd4, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{1,1,0, 32'h13, 32'h0, 32'hCAFEF00D, 1,  1,1,0, 10'd4, 32'h0,        32'h0};
        vecs[7]  = '{1,1,0, 32'h13, 32'h0, 32'h0,        0,  0,0,0, 10'd4, 32'h0,        32'hCAFEF00D};
        // Non-memory op and invalid slot with spurious acks.
        vecs[8]  = '{1,0,0, 32'h44, 32'h9, 32'hFFFF0000, 1,  0,0,0, 10'd4, 32'h0,        32'h0};
        vecs[9]  = '{0,1,1, 32'h48, 32'h9, 32'hFFFF0000, 1,  0,0,0, 10'd4, 32'h0,        32'h0};
        // Both isLd and isSt: read issued, no write.
        vecs[10] = '{1,1,1, 32'h20, 32'h1234, 32'h0,        0,  1,0,0, 10'd4, 32'h0,    32'h0};
        vecs[11] = '{1,1,1, 32'h20, 32'h1234, 32'h5555AAAA, 0,  1,1,0, 10'd8, 32'h1234, 32'h0};
        vecs[12] = '{1,1,1, 32'h20, 32'h1234, 32'h5555AAAA, 1,  1,1,0, 10'd8, 32'h1234, 32'h0};
        vecs[13] = '{1,1,1, 32'h20, 32'h1234, 32'h0,        0,  0,0,0, 10'd8, 32'h1234, 32'h5555AAAA};
        vecs[14] = '{0,0,0, 32'h0,  32'h0,    32'h0,        0,  0,0,0, 10'd8, 32'h1234, 32'h0};

        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        repeat (3) @(negedge clk);
        #1;
        check_ctl("reset", 0, 0, 32'h0, 0);
        check("reset.mem_we",    32'(mem.mem_we),   32'h0);
        check("reset.mem_addr",  32'(mem.mem_addr), 32'h0);
        check("reset.mem_wdata", mem.mem_wdata,     32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].mv, vecs[i].ld, vecs[i].st, vecs[i].alu, vecs[i].op2, vecs[i].rd, vecs[i].ack);
            check_ctl($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_req, vecs[i].e_ld, 1'b0);
            check($sformatf("v%0d.mem_we", i),    32'(mem.mem_we),   32'(vecs[i].e_we));
            check($sformatf("v%0d.mem_addr", i),  32'(mem.mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d.mem_wdata", i), mem.mem_wdata,     vecs[i].e_wdata);
        end

        // Reset asserted mid-REQ with the load still presented in MA.
        cycle(1, 1, 0, 32'h40, 32'h0, 32'h0, 0);
        check_ctl("rst.start", 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h40, 32'h0, 32'hBAD0BAD0, 0);
        check_ctl("rst.req", 1, 1, 32'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_ctl("rst.abort", 0, 0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ctl("rst.restart", 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 1);
        check_ctl("rst.req2", 1, 1, 32'h0, 0);
        check("rst.req2.mem_addr", 32'(mem.mem_addr), 32'h10);
        cycle(1, 1, 0, 32'h40, 32'h0, 32'h0, 0);
        check_ctl("rst.done", 0, 0, 32'hDEADBEEF, 0);
        cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        check_ctl("rst.idle", 0, 0, 32'h0, 0);

`ifdef LSU_TIMEOUT_EN
        // No ack: four REQ cycles, then an error DONE cycle.
        cycle(1, 1, 0, 32'h80, 32'h0, 32'h0, 0);
        check_ctl("to.start", 1, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, 0, 32'h80, 32'h0, 32'h0, 0);
            check_ctl($sformatf("to.req%0d", k), 1, 1, 32'h0, 0);
        end
        cycle(1, 1, 0, 32'h80, 32'h0, 32'h0, 0);
        check_ctl("to.done", 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        check_ctl("to.idle", 0, 0, 32'h0, 0);

        // Ack on the expiry cycle wins.
        cycle(1, 1, 0, 32'h84, 32'h0, 32'h0, 0);
        check_ctl("toack.start", 1, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, 0, 32'h84, 32'h0, 32'h00000077, (k == 3) ? 1'b1 : 1'b0);
            check_ctl($sformatf("toack.req%0d", k), 1, 1, 32'h0, 0);
        end
        cycle(1, 1, 0, 32'h84, 32'h0, 32'h0, 0);
        check_ctl("toack.done", 0, 0, 32'h00000077, 0);
        cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        check_ctl("toack.idle", 0, 0, 32'h0, 0);
`else
        // Without the timeout a slow memory is waited for indefinitely.
        cycle(1, 1, 0, 32'h80, 32'h0, 32'h0, 0);
        check_ctl("slow.start", 1, 0, 32'h0, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 1, 0, 32'h80, 32'h0, 32'h00000123, (k == 9) ? 1'b1 : 1'b0);
            check_ctl($sformatf("slow.req%0d", k), 1, 1, 32'h0, 0);
        end
        cycle(1, 1, 0, 32'h80, 32'h0, 32'h0, 0);
        check_ctl("slow.done", 0, 0, 32'h00000123, 0);
        cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        check_ctl("slow.idle", 0, 0, 32'h0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
